pc_sequencer: RTL and testbench

Instruction-cycle controller for the 11-bit program counter. Steps a fixed FETCH/DECODE/EXECUTE/WRITEBACK cycle and drives the PC's enable and next-address inputs. Handles sequential advance, jumps, conditional branches, halt and stall. Sits between the instruction decoder and the ProgramCounter; pc_en and pc_in connect directly to the PC's enable and in ports.

---
 rtl/pc_sequencer_if.sv | 36 +++
 rtl/pc_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Decoder/ProgramCounter-side signal bundle for pc_sequencer.
// master = decoder/PC side, slave = the sequencer itself.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              start;
  logic              stall;
  logic [ADDR_W-1:0] pc;
  logic              is_jump;
  logic              is_branch;
  logic              branch_taken;
  logic              is_call;
  logic              is_ret;
  logic              is_halt;
  logic [ADDR_W-1:0] target;
  logic              pc_en;
  logic [ADDR_W-1:0] pc_in;
  logic              ir_load;
  logic              exec_en;
  logic              wb_en;
  logic [2:0]        state;
  logic              halted;
  logic              stack_err;

  modport master (
    output start, stall, pc, is_jump, is_branch, branch_taken,
           is_call, is_ret, is_halt, target,
    input  pc_en, pc_in, ir_load, exec_en, wb_en, state, halted, stack_err
  );

  modport slave (
    input  start, stall, pc, is_jump, is_branch, branch_taken,
           is_call, is_ret, is_halt, target,
    output pc_en, pc_in, ir_load, exec_en, wb_en, state, halted, stack_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// FETCH/DECODE/EXECUTE/WRITEBACK controller driving the program counter.
// Optional return stack enabled by defining CALL_STACK_EN.
module pc_sequencer #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned RESET_VEC   = 0,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  pc_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              jump_q, jump_d;
  logic              branch_q, branch_d;
  logic              taken_q, taken_d;
  logic              halt_q, halt_d;
  logic [ADDR_W-1:0] target_q, target_d;

  logic              jump_in_s;
  logic [ADDR_W-1:0] seq_pc_s;
  logic [ADDR_W-1:0] pc_in_s;
  logic              pc_en_s, ir_load_s, exec_en_s, wb_en_s;

`ifdef CALL_STACK_EN
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              call_q, call_d;
  logic              ret_q, ret_d;
  logic              err_q, err_d;
  logic [SP_W-1:0]   sp_dec_s;
  logic [IDX_W-1:0]  push_idx_s, pop_idx_s;

  assign jump_in_s  = bus.is_jump;
  assign sp_dec_s   = sp_q - SP_W'(1);
  assign push_idx_s = sp_q[IDX_W-1:0];
  assign pop_idx_s  = sp_dec_s[IDX_W-1:0];
  assign bus.stack_err = err_q;
`else
  // Without the stack a call is indistinguishable from a jump.
  logic unused_ret_s;
  assign jump_in_s     = bus.is_jump | bus.is_call;
  assign unused_ret_s  = bus.is_ret;
  assign bus.stack_err = 1'b0;
`endif

  assign seq_pc_s = bus.pc + ADDR_W'(1);

  // Next-state, decode latching, strobe and next-PC selection.
  always_comb begin
    state_d   = state_q;
    jump_d    = jump_q;
    branch_d  = branch_q;
    taken_d   = taken_q;
    halt_d    = halt_q;
    target_d  = target_q;
    pc_in_s   = bus.pc;
    pc_en_s   = 1'b0;
    ir_load_s = 1'b0;
    exec_en_s = 1'b0;
    wb_en_s   = 1'b0;
`ifdef CALL_STACK_EN
    stack_d = stack_q;
    sp_d    = sp_q;
    call_d  = call_q;
    ret_d   = ret_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pc_en_s = 1'b1;
          pc_in_s = ADDR_W'(RESET_VEC);
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (bus.stall) begin
          state_d = FETCH;
        end else begin
          ir_load_s = 1'b1;
          state_d   = DECODE;
        end
      end
      DECODE: begin
        if (bus.stall) begin
          state_d = DECODE;
        end else begin
          jump_d   = jump_in_s;
          branch_d = bus.is_branch;
          taken_d  = bus.branch_taken;
          halt_d   = bus.is_halt;
          target_d = bus.target;
`ifdef CALL_STACK_EN
          call_d   = bus.is_call;
          ret_d    = bus.is_ret;
`endif
          state_d  = EXECUTE;
        end
      end
      EXECUTE: begin
        if (bus.stall) begin
          state_d = EXECUTE;
        end else begin
          exec_en_s = 1'b1;
          state_d   = halt_q ? HALT : WRITEBACK;
        end
      end
      WRITEBACK: begin
        if (bus.stall) begin
          state_d = WRITEBACK;
        end else begin
          wb_en_s = 1'b1;
          pc_en_s = 1'b1;
          state_d = FETCH;
          // Priority: ret > call > jump > taken branch > sequential.
`ifdef CALL_STACK_EN
          if (ret_q) begin
            if (sp_q == {SP_W{1'b0}}) begin
              err_d   = 1'b1;
              pc_in_s = seq_pc_s;
            end else begin
              pc_in_s = stack_q[pop_idx_s];
              sp_d    = sp_dec_s;
            end
          end else if (call_q) begin
            pc_in_s = target_q;
            if (sp_q == SP_W'(STACK_DEPTH)) begin
              err_d = 1'b1;
            end else begin
              stack_d[push_idx_s] = seq_pc_s;
              sp_d                = sp_q + SP_W'(1);
            end
          end else
`endif
          if (jump_q) begin
            pc_in_s = target_q;
          end else if (branch_q && taken_q) begin
            pc_in_s = target_q;
          end else begin
            pc_in_s = seq_pc_s;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, decode latch and return-stack registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      jump_q   <= 1'b0;
      branch_q <= 1'b0;
      taken_q  <= 1'b0;
      halt_q   <= 1'b0;
      target_q <= {ADDR_W{1'b0}};
`ifdef CALL_STACK_EN
      sp_q     <= {SP_W{1'b0}};
      call_q   <= 1'b0;
      ret_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      jump_q   <= jump_d;
      branch_q <= branch_d;
      taken_q  <= taken_d;
      halt_q   <= halt_d;
      target_q <= target_d;
`ifdef CALL_STACK_EN
      stack_q  <= stack_d;
      sp_q     <= sp_d;
      call_q   <= call_d;
      ret_q    <= ret_d;
      err_q    <= err_d;
`endif
    end
  end

  // A start seen together with reset must not load the PC.
  assign bus.pc_en   = pc_en_s & ~reset;
  assign bus.pc_in   = pc_in_s;
  assign bus.ir_load = ir_load_s;
  assign bus.exec_en = exec_en_s;
  assign bus.wb_en   = wb_en_s;
  assign bus.state   = state_q;
  assign bus.halted  = (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default build and CALL_STACK_EN).
module tb_pc_sequencer;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  pc_sequencer_if #(.ADDR_W(11)) bus ();

  pc_sequencer #(
    .ADDR_W      (11),
    .RESET_VEC   (0),
    .STACK_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {state, ir_load, exec_en, wb_en, pc_en}
  function automatic logic [31:0] strobes();
    return {25'd0, bus.state, bus.ir_load, bus.exec_en, bus.wb_en, bus.pc_en};
  endfunction

  task automatic clear_dec();
    bus.is_jump      = 1'b0;
    bus.is_branch    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.is_call      = 1'b0;
    bus.is_ret       = 1'b0;
    bus.is_halt      = 1'b0;
  endtask

  // Called in IDLE, #1 after an edge; leaves the DUT in FETCH.
  task automatic do_start();
    bus.start = 1'b1;
    #1;
    chk("start_pc_en", {31'd0, bus.pc_en}, 32'd1);
    chk("start_pc_in", {21'd0, bus.pc_in}, 32'd0);
    tick();
    bus.start = 1'b0;
  endtask

  // Called in FETCH; ends in FETCH (or HALT when h=1).
  task automatic run_instr(input string tag, input logic [10:0] pcv,
                           input logic j, input logic b, input logic t,
                           input logic c, input logic r, input logic h,
                           input logic [10:0] tgt, input logic [10:0] exp_pc);
    bus.pc = pcv;
    #1;
    chk({tag, "_fetch"}, strobes(), {25'd0, 3'd1, 4'b1000});
    tick();
    bus.is_jump = j; bus.is_branch = b; bus.branch_taken = t;
    bus.is_call = c; bus.is_ret = r; bus.is_halt = h; bus.target = tgt;
    #1;
    chk({tag, "_decode"}, strobes(), {25'd0, 3'd2, 4'b0000});
    tick();
    clear_dec();
    bus.target = ~tgt;
    #1;
    chk({tag, "_exec"}, strobes(), {25'd0, 3'd3, 4'b0100});
    tick();
    if (h) begin
      chk({tag, "_halt"}, {24'd0, bus.state, bus.halted, bus.pc_en, 3'd0},
          {24'd0, 3'd5, 1'b1, 1'b0, 3'd0});
    end else begin
      chk({tag, "_wb"}, strobes(), {25'd0, 3'd4, 4'b0011});
      chk({tag, "_pc_in"}, {21'd0, bus.pc_in}, {21'd0, exp_pc});
      tick();
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.pc = 11'd0;
    bus.target = 11'd0;
    clear_dec();
    tick();
    tick();
    bus.start = 1'b1;
    #1;
    chk("rst_state", {29'd0, bus.state}, 32'd0);
    chk("rst_flags", {29'd0, bus.halted, bus.stack_err, bus.pc_en}, 32'd0);
    bus.start = 1'b0;
    reset = 1'b0;
    tick();
    chk("idle_hold", strobes(), {25'd0, 3'd0, 4'b0000});

    do_start();
    run_instr("seq",    11'd0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h3AA, 11'd1);
    run_instr("wrap",   11'd2047,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h3AA, 11'd0);
    run_instr("jump",   11'd0,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h155, 11'h155);
    run_instr("br_nt",  11'h155,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h020, 11'h156);
    run_instr("br_t",   11'h155,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h020, 11'h020);
    run_instr("tk_only",11'h020,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h300, 11'h021);

    // Stall for three cycles in EXECUTE: 7 cycles FETCH to FETCH.
    bus.pc = 11'h030;
    #1;
    chk("stl_fetch", strobes(), {25'd0, 3'd1, 4'b1000});
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1'b1;
      #1;
      chk("stl_exec_hold", strobes(), {25'd0, 3'd3, 4'b0000});
      tick();
    end
    bus.stall = 1'b0;
    #1;
    chk("stl_exec", strobes(), {25'd0, 3'd3, 4'b0100});
    tick();
    chk("stl_wb", strobes(), {25'd0, 3'd4, 4'b0011});
    chk("stl_pc_in", {21'd0, bus.pc_in}, 32'h031);
    tick();
    chk("stl_refetch", strobes(), {25'd0, 3'd1, 4'b1000});

`ifdef CALL_STACK_EN
    run_instr("call", 11'h010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h100, 11'h100);
    run_instr("ret",  11'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h3FF, 11'h011);
    chk("ret_err_clear", {31'd0, bus.stack_err}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      run_instr("ncall", 11'h200 + 11'(k), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                11'h200 + 11'(k + 1), 11'h200 + 11'(k + 1));
    end
    chk("ncall4_err", {31'd0, bus.stack_err}, 32'd0);
    run_instr("ncall5", 11'h204, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h2F0, 11'h2F0);
    chk("ncall5_err", {31'd0, bus.stack_err}, 32'd1);
    run_instr("ret_top", 11'h2F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000, 11'h204);
    chk("err_sticky", {31'd0, bus.stack_err}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_err", {31'd0, bus.stack_err}, 32'd0);
    do_start();
    run_instr("ret_empty", 11'h050, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h3C0, 11'h051);
    chk("ret_empty_err", {31'd0, bus.stack_err}, 32'd1);
`else
    run_instr("call", 11'h010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h100, 11'h100);
    run_instr("ret",  11'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h3FF, 11'h101);
    chk("no_stack_err", {31'd0, bus.stack_err}, 32'd0);
`endif

    run_instr("halt", 11'h060, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 11'h000);
    bus.start = 1'b1;
    bus.stall = 1'b1;
    #1;
    chk("halt_start_pc_en", {31'd0, bus.pc_en}, 32'd0);
    tick();
    chk("halt_stays", {29'd0, bus.state}, 32'd5);
    chk("halt_strobes", strobes(), {25'd0, 3'd5, 4'b0000});
    bus.start = 1'b0;
    bus.stall = 1'b0;
    reset = 1'b1;
    tick();
    chk("halt_reset", {28'd0, bus.state, bus.halted}, 32'd0);
    reset = 1'b0;
    tick();
    chk("post_reset_idle", strobes(), {25'd0, 3'd0, 4'b0000});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
